fetch_stage: RTL and testbench

- IF stage of the pipelined RV32 core, directly upstream of decode.
- Holds the PC and issues instruction-memory requests over a valid/ready request and response interface, with at most one request outstanding.
- Registers each fetched instruction into the IF/ID register (instr_f, pc_f, pc_plus4_f), which decode consumes.
- Handles decode stalls, execute-stage redirects (taken branch or jump) and discarding of stale responses.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_stage_if_id_reg.sv | 68 ++++++
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and its pipeline register.
package fetch_stage_pkg;

    localparam int unsigned ADDR_W_DEF    = 32;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    // addi x0,x0,0 used as the pipeline bubble
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_BUF  = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register with load, hold and flush-to-bubble control.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned             ADDRESS_WIDTH = ADDR_W_DEF,
    parameter int unsigned             DATA_WIDTH    = DATA_W_DEF,
    parameter logic [DATA_WIDTH-1:0]   NOP_INSTR     = DATA_WIDTH'(NOP_INSTR_DEF)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     load_i,
    input  logic                     hold_i,
    input  logic [DATA_WIDTH-1:0]    instr_i,
    input  logic [ADDRESS_WIDTH-1:0] pc_i,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_i,
    output logic [DATA_WIDTH-1:0]    instr_o,
    output logic [ADDRESS_WIDTH-1:0] pc_o,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_o,
    output logic                     valid_o
);

    logic [DATA_WIDTH-1:0]    instr_q, instr_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
    logic                     valid_q, valid_d;

    // Priority: flush, then load, then hold; otherwise insert a bubble keeping the PCs.
    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d    = instr_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
        end else if (!hold_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    // Register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, single-outstanding imem requests, skid buffer, IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = ADDR_W_DEF,
    parameter int unsigned              DATA_WIDTH    = DATA_W_DEF,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(RESET_PC_DEF),
    parameter logic [DATA_WIDTH-1:0]    NOP_INSTR     = DATA_WIDTH'(NOP_INSTR_DEF)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_d,
    input  logic                     redirect_e,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc_e,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
    output logic [DATA_WIDTH-1:0]    instr_f,
    output logic [ADDRESS_WIDTH-1:0] pc_f,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
    output logic                     valid_f
);

    fetch_state_e             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0]    skid_q, skid_d;

    logic [ADDRESS_WIDTH-1:0] pc_plus4_c;
    logic [ADDRESS_WIDTH-1:0] target_c;
    logic                     req_accept_c;
    logic                     ld_c;
    logic [DATA_WIDTH-1:0]    ld_instr_c;

    assign pc_plus4_c   = pc_q + ADDRESS_WIDTH'(4);
    assign target_c     = {redirect_pc_e[ADDRESS_WIDTH-1:2], 2'b00};
    assign req_accept_c = imem_req_valid & imem_req_ready;

    // State, PC and skid buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            skid_q  <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
        end
    end

    // Next state, PC, skid buffer and IF/ID load control; redirect overrides everything.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        skid_d     = skid_q;
        ld_c       = 1'b0;
        ld_instr_c = skid_q;
        if (redirect_e) begin
            pc_d   = target_c;
            skid_d = NOP_INSTR;
            unique case (state_q)
                ST_REQ:  state_d = req_accept_c ? ST_DROP : ST_REQ;
                ST_WAIT: state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
                ST_BUF:  state_d = ST_REQ;
                ST_DROP: state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
                default: state_d = ST_REQ;
            endcase
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (req_accept_c) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (!stall_d) begin
                            ld_c       = 1'b1;
                            ld_instr_c = imem_rsp_data;
                            pc_d       = pc_plus4_c;
                            state_d    = req_accept_c ? ST_WAIT : ST_REQ;
                        end else begin
                            skid_d  = imem_rsp_data;
                            state_d = ST_BUF;
                        end
                    end
                end
                ST_BUF: begin
                    if (!stall_d) begin
                        ld_c       = 1'b1;
                        ld_instr_c = skid_q;
                        pc_d       = pc_plus4_c;
                        state_d    = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_rsp_valid) state_d = ST_REQ;
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    // Request outputs; in WAIT the next request is bypassed on a delivering response.
    always_comb begin
        imem_req_valid = 1'b0;
        imem_addr      = pc_q;
        unique case (state_q)
            ST_REQ: begin
                imem_req_valid = 1'b1;
                imem_addr      = pc_q;
            end
            ST_WAIT: begin
                imem_req_valid = imem_rsp_valid & ~stall_d & ~redirect_e;
                imem_addr      = pc_plus4_c;
            end
            default: begin
                imem_req_valid = 1'b0;
                imem_addr      = pc_q;
            end
        endcase
    end

    // IF/ID pipeline register.
    if_id_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .NOP_INSTR     (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (redirect_e),
        .load_i     (ld_c),
        .hold_i     (stall_d),
        .instr_i    (ld_instr_c),
        .pc_i       (pc_q),
        .pc_plus4_i (pc_plus4_c),
        .instr_o    (instr_f),
        .pc_o       (pc_f),
        .pc_plus4_o (pc_plus4_f),
        .valid_o    (valid_f)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// checked against a delivery-sequence model with a behavioural memory.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_d = 1'b0;
    logic        redirect_e = 1'b0;
    logic [31:0] redirect_pc_e = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic        valid_f;

    int errors = 0;
    int checks = 0;

    // behavioural memory: one pending response with a countdown
    bit          mem_busy = 0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt = 0;
    bit          force_rsp = 0;

    // values seen before the active edge of the last cycle
    bit          pre_req_valid, pre_accept, pre_rsp;
    logic [31:0] pre_addr;
    bit          overlap;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_d        (stall_d),
        .redirect_e     (redirect_e),
        .redirect_pc_e  (redirect_pc_e),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_f        (instr_f),
        .pc_f           (pc_f),
        .pc_plus4_f     (pc_plus4_f),
        .valid_f        (valid_f)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'(a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input bit rdy, input bit stl, input bit rd,
                         input logic [31:0] rpc, input int lat);
        bit mem_rsp;
        imem_req_ready = rdy;
        stall_d        = stl;
        redirect_e     = rd;
        redirect_pc_e  = rpc;
        mem_rsp        = mem_busy && (mem_cnt == 0);
        imem_rsp_valid = mem_rsp || force_rsp;
        imem_rsp_data  = mem_rsp ? memf(mem_addr) : (force_rsp ? 32'hDEAD_BEEF : $urandom);
        #1;
        pre_req_valid = imem_req_valid;
        pre_addr      = imem_addr;
        pre_accept    = imem_req_valid && rdy;
        pre_rsp       = mem_rsp;
        overlap       = pre_accept && mem_busy && !mem_rsp;
        @(posedge clk);
        #1;
        if (mem_rsp) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (pre_accept) begin
            mem_busy = 1;
            mem_addr = pre_addr;
            mem_cnt  = lat - 1;
        end
        force_rsp = 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        stall_d        = 1'b0;
        redirect_e     = 1'b0;
        imem_rsp_valid = 1'b0;
        mem_busy       = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (valid_f !== 1'b0 || instr_f !== NOP || pc_f !== 32'h0 || pc_plus4_f !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b instr=%h pc=%h pc4=%h, want 0 %h 0 0",
                     valid_f, instr_f, pc_f, pc_plus4_f, NOP);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            cycle(1, 0, 0, 32'h0, 1);
            checks++;
            if (pre_req_valid !== 1'b1 || pre_addr !== 32'(4 * k)) begin
                errors++;
                $display("FAIL zw_addr: req=%0b addr=%h, want 1 %h", pre_req_valid, pre_addr, 32'(4 * k));
            end
            if (k > 0) begin
                checks++;
                if (valid_f !== 1'b1 || pc_f !== 32'(4 * (k - 1)) ||
                    instr_f !== memf(32'(4 * (k - 1))) || pc_plus4_f !== 32'(4 * k)) begin
                    errors++;
                    $display("FAIL zw_deliver: valid=%0b pc=%h instr=%h pc4=%h, want 1 %h %h %h",
                             valid_f, pc_f, instr_f, pc_plus4_f, 32'(4 * (k - 1)),
                             memf(32'(4 * (k - 1))), 32'(4 * k));
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) cycle(1, 0, 0, 32'h0, 1);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 1, 0, 32'h0, 1);
            checks++;
            if (valid_f !== 1'b1 || pc_f !== 32'h4 || instr_f !== memf(32'h4) || pre_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: valid=%0b pc=%h req=%0b, want 1 00000004 0",
                         valid_f, pc_f, pre_req_valid);
            end
        end
        cycle(1, 0, 0, 32'h0, 1);
        checks++;
        if (valid_f !== 1'b1 || pc_f !== 32'h8 || instr_f !== memf(32'h8) || pc_plus4_f !== 32'hC) begin
            errors++;
            $display("FAIL stall_release: valid=%0b pc=%h instr=%h, want 1 00000008 %h",
                     valid_f, pc_f, instr_f, memf(32'h8));
        end
        cycle(1, 0, 0, 32'h0, 1);
        checks++;
        if (pre_addr !== 32'hC || valid_f !== 1'b0 || instr_f !== NOP || pc_f !== 32'h8) begin
            errors++;
            $display("FAIL stall_bubble: addr=%h valid=%0b instr=%h pc=%h, want 0000000c 0 %h 00000008",
                     pre_addr, valid_f, instr_f, pc_f, NOP);
        end
        cycle(1, 0, 0, 32'h0, 1);
        checks++;
        if (valid_f !== 1'b1 || pc_f !== 32'hC || instr_f !== memf(32'hC)) begin
            errors++;
            $display("FAIL stall_next: valid=%0b pc=%h, want 1 0000000c", valid_f, pc_f);
        end
    endtask

    task automatic test_redirect_outstanding();
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1, 0, 0, 32'h0, (k == 4) ? 2 : 1);
        checks++;
        if (pre_accept !== 1'b1 || pre_addr !== 32'h10) begin
            errors++;
            $display("FAIL redir_setup: acc=%0b addr=%h, want 1 00000010", pre_accept, pre_addr);
        end
        cycle(1, 0, 1, 32'h100, 1);
        checks++;
        if (valid_f !== 1'b0 || instr_f !== NOP) begin
            errors++;
            $display("FAIL redir_flush: valid=%0b instr=%h, want 0 %h", valid_f, instr_f, NOP);
        end
        cycle(1, 0, 0, 32'h0, 1);
        checks++;
        if (valid_f !== 1'b0 || pre_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_drop: valid=%0b req=%0b, want 0 0", valid_f, pre_req_valid);
        end
        cycle(1, 0, 0, 32'h0, 1);
        checks++;
        if (pre_accept !== 1'b1 || pre_addr !== 32'h100 || valid_f !== 1'b0) begin
            errors++;
            $display("FAIL redir_req: acc=%0b addr=%h valid=%0b, want 1 00000100 0",
                     pre_accept, pre_addr, valid_f);
        end
        cycle(1, 0, 0, 32'h0, 1);
        checks++;
        if (valid_f !== 1'b1 || pc_f !== 32'h100 || instr_f !== memf(32'h100)) begin
            errors++;
            $display("FAIL redir_deliver: valid=%0b pc=%h instr=%h, want 1 00000100 %h",
                     valid_f, pc_f, instr_f, memf(32'h100));
        end
    endtask

    task automatic test_redirect_buf();
        do_reset();
        repeat (2) cycle(1, 0, 0, 32'h0, 1);
        cycle(1, 1, 0, 32'h0, 1);
        cycle(1, 1, 1, 32'h203, 1);
        checks++;
        if (valid_f !== 1'b0 || instr_f !== NOP) begin
            errors++;
            $display("FAIL buf_flush: valid=%0b instr=%h, want 0 %h", valid_f, instr_f, NOP);
        end
        cycle(1, 0, 0, 32'h0, 1);
        checks++;
        if (pre_accept !== 1'b1 || pre_addr !== 32'h200 || valid_f !== 1'b0) begin
            errors++;
            $display("FAIL buf_target: acc=%0b addr=%h valid=%0b, want 1 00000200 0",
                     pre_accept, pre_addr, valid_f);
        end
        cycle(1, 0, 0, 32'h0, 1);
        checks++;
        if (valid_f !== 1'b1 || pc_f !== 32'h200 || instr_f !== memf(32'h200)) begin
            errors++;
            $display("FAIL buf_deliver: valid=%0b pc=%h, want 1 00000200", valid_f, pc_f);
        end
    endtask

    task automatic test_ready_low();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 32'h0, 1);
            checks++;
            if (pre_req_valid !== 1'b1 || pre_addr !== 32'h0 || valid_f !== 1'b0 || instr_f !== NOP) begin
                errors++;
                $display("FAIL rdy_low: req=%0b addr=%h valid=%0b instr=%h, want 1 0 0 %h",
                         pre_req_valid, pre_addr, valid_f, instr_f, NOP);
            end
        end
        cycle(1, 0, 0, 32'h0, 1);
        checks++;
        if (pre_accept !== 1'b1 || pre_addr !== 32'h0) begin
            errors++;
            $display("FAIL rdy_accept: acc=%0b addr=%h, want 1 0", pre_accept, pre_addr);
        end
        cycle(1, 0, 0, 32'h0, 1);
        checks++;
        if (valid_f !== 1'b1 || pc_f !== 32'h0 || instr_f !== memf(32'h0)) begin
            errors++;
            $display("FAIL rdy_deliver: valid=%0b pc=%h, want 1 0", valid_f, pc_f);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (2) cycle(1, 0, 0, 32'h0, 1);
        cycle(1, 0, 1, 32'hFFFF_FFFC, 1);
        checks++;
        if (pre_req_valid !== 1'b0 || valid_f !== 1'b0) begin
            errors++;
            $display("FAIL wrap_nobypass: req=%0b valid=%0b, want 0 0", pre_req_valid, valid_f);
        end
        cycle(1, 0, 0, 32'h0, 1);
        cycle(1, 0, 0, 32'h0, 1);
        checks++;
        if (valid_f !== 1'b1 || pc_f !== 32'hFFFF_FFFC || pc_plus4_f !== 32'h0 ||
            instr_f !== memf(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL wrap_top: valid=%0b pc=%h pc4=%h, want 1 fffffffc 0", valid_f, pc_f, pc_plus4_f);
        end
        cycle(1, 0, 0, 32'h0, 1);
        checks++;
        if (valid_f !== 1'b1 || pc_f !== 32'h0 || pc_plus4_f !== 32'h4 || instr_f !== memf(32'h0)) begin
            errors++;
            $display("FAIL wrap_zero: valid=%0b pc=%h pc4=%h, want 1 0 4", valid_f, pc_f, pc_plus4_f);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1, 0, 0, 32'h0, 1);
        cycle(1, 0, 0, 32'h0, 4);
        cycle(1, 0, 0, 32'h0, 1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid_f !== 1'b0 || instr_f !== NOP || pc_f !== 32'h0 || pc_plus4_f !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: valid=%0b instr=%h pc=%h pc4=%h, want 0 %h 0 0",
                     valid_f, instr_f, pc_f, pc_plus4_f, NOP);
        end
        mem_busy = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        force_rsp = 1;
        cycle(1, 0, 0, 32'h0, 1);
        checks++;
        if (pre_accept !== 1'b1 || pre_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_restart: acc=%0b addr=%h, want 1 0", pre_accept, pre_addr);
        end
        cycle(1, 0, 0, 32'h0, 1);
        checks++;
        if (valid_f !== 1'b1 || pc_f !== 32'h0 || instr_f !== memf(32'h0)) begin
            errors++;
            $display("FAIL rst_deliver: valid=%0b pc=%h instr=%h, want 1 0 %h",
                     valid_f, pc_f, instr_f, memf(32'h0));
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, p_instr, p_pc, p_pc4, rpc;
        bit          p_valid, rdy, stl, rd;
        int          delivered, idle;
        do_reset();
        exp_pc    = 32'h0;
        delivered = 0;
        idle      = 0;
        for (int n = 0; n < 3000; n++) begin
            p_instr = instr_f; p_pc = pc_f; p_pc4 = pc_plus4_f; p_valid = valid_f;
            rdy = ($urandom % 4) != 0;
            stl = ($urandom % 5) == 0;
            rd  = ($urandom % 40) == 0;
            rpc = ($urandom % 3 == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            cycle(rdy, stl, rd, rpc, 1 + int'($urandom % 3));
            checks++;
            if (overlap || (pre_req_valid && pre_addr[1:0] != 2'b00)) begin
                errors++;
                $display("FAIL rnd_req: overlap=%0b addr=%h cycle=%0d, want 0 and aligned", overlap, pre_addr, n);
            end
            checks++;
            idle++;
            if (rd) begin
                exp_pc = rpc & 32'hFFFF_FFFC;
                if (valid_f !== 1'b0 || instr_f !== NOP) begin
                    errors++;
                    $display("FAIL rnd_flush: valid=%0b instr=%h cycle=%0d, want 0 %h", valid_f, instr_f, n, NOP);
                end
            end else if (stl) begin
                if (valid_f !== p_valid || instr_f !== p_instr || pc_f !== p_pc || pc_plus4_f !== p_pc4) begin
                    errors++;
                    $display("FAIL rnd_hold: valid=%0b pc=%h instr=%h cycle=%0d, want %0b %h %h",
                             valid_f, pc_f, instr_f, n, p_valid, p_pc, p_instr);
                end
            end else if (valid_f === 1'b1) begin
                if (pc_f !== exp_pc || instr_f !== memf(exp_pc) || pc_plus4_f !== 32'(exp_pc + 32'd4)) begin
                    errors++;
                    $display("FAIL rnd_deliver: pc=%h instr=%h pc4=%h cycle=%0d, want %h %h %h",
                             pc_f, instr_f, pc_plus4_f, n, exp_pc, memf(exp_pc), 32'(exp_pc + 32'd4));
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
                idle = 0;
            end else begin
                if (instr_f !== NOP || pc_f !== p_pc || pc_plus4_f !== p_pc4) begin
                    errors++;
                    $display("FAIL rnd_bubble: instr=%h pc=%h cycle=%0d, want %h %h", instr_f, pc_f, n, NOP, p_pc);
                end
            end
            if (idle > 300) begin
                errors++;
                $display("FAIL rnd_progress: no delivery for %0d cycles, want under 300", idle);
                break;
            end
        end
        checks++;
        if (delivered < 200) begin
            errors++;
            $display("FAIL rnd_count: delivered=%0d, want at least 200", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_outstanding();
        test_redirect_buf();
        test_ready_low();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
